muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 93 +++++++++
 tb/tb_muldiv_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Ports: clk, rst (sync active-low), start/funct3/a/b request (sampled in IDLE),
//        flush aborts; busy = not IDLE, done one-cycle pulse, result held until next op.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic [XLEN-1:0] ra, rb, m;
  logic [2*XLEN-1:0] p, pv, mul_p, div_p;
  logic neg_q, neg_r, dz, ov;
  logic sa, sb, a_neg, b_neg, zero, ovf, ge;
  logic [XLEN-1:0] a_abs, b_abs, hi, lo, nr, fin_res;
  logic [XLEN:0] ms, r_sh;
  // p holds {acc, multiplier} while multiplying and {remainder, dividend/quotient} while dividing
  assign hi = p[2*XLEN-1:XLEN];
  assign lo = p[XLEN-1:0];
  assign sa = (op == 3'b001) || (op == 3'b010) || (op[2] && !op[0]);
  assign sb = (op == 3'b001) || (op[2] && !op[0]);
  assign a_neg = sa && ra[XLEN-1];
  assign b_neg = sb && rb[XLEN-1];
  assign a_abs = a_neg ? -ra : ra;
  assign b_abs = b_neg ? -rb : rb;
  assign zero = op[2] && (rb == '0);
  assign ovf = op[2] && !op[0] && (ra == {1'b1, {(XLEN-1){1'b0}}}) && (rb == '1);
  assign ms = {1'b0, hi} + (p[0] ? {1'b0, m} : '0);
  assign mul_p = {ms, p[XLEN-1:1]};
  assign r_sh = {hi, p[XLEN-1]};
  assign ge = r_sh >= {1'b0, m};
  assign nr = ge ? XLEN'(r_sh - {1'b0, m}) : r_sh[XLEN-1:0];
  assign div_p = {nr, p[XLEN-2:0], ge};
  assign pv = neg_q ? -p : p;
  assign fin_res = dz ? (op[1] ? ra : '1) :
                   ov ? (op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}}) :
                   op[2] ? (op[1] ? (neg_r ? -hi : hi) : (neg_q ? -lo : lo)) :
                   (op[1:0] == 2'b00 ? pv[XLEN-1:0] : pv[2*XLEN-1:XLEN]);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? PREP : IDLE;
      PREP: state_n = (zero || ovf) ? FIN : CALC;
      CALC: state_n = (cnt == CW'(XLEN-1)) ? FIN : CALC;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
      result <= '0;
    end else begin
      state <= state_n;
      done <= (state == FIN) && !flush;
      if ((state == FIN) && !flush) result <= fin_res;
      if ((state == IDLE) && start && !flush) begin
        op <= funct3;
        ra <= a;
        rb <= b;
      end
      if (state == PREP) begin
        p <= {{XLEN{1'b0}}, a_abs};
        m <= b_abs;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz <= zero;
        ov <= ovf;
        cnt <= '0;
      end
      if (state == CALC) begin
        cnt <= cnt + 1'b1;
        p <= op[2] ? div_p : mul_p;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
  logic clk, rst, start, flush, busy, done;
  logic [2:0] funct3;
  logic [31:0] a, b, result, last;
  int checks = 0, failures = 0;
  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, uy;
    logic [63:0] pr;
    logic ovf;
    sx = $signed(x);
    sy = $signed(y);
    uy = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin pr = sx * sy; return pr[31:0]; end
      3'd1: begin pr = sx * sy; return pr[63:32]; end
      3'd2: begin pr = sx * uy; return pr[63:32]; end
      3'd3: begin pr = {32'b0, x} * {32'b0, y}; return pr[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        pr = sx / sy; return pr[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        pr = sx % sy; return pr[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction
  // Issue one op from a non-edge time; returns #1 after the edge on which done is seen.
  task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input int inj);
    int n, lat;
    logic [31:0] exp;
    exp = model(f, x, y);
    lat = (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) ? 2 : 34;
    start = 1; funct3 = f; a = x; b = y;
    @(posedge clk); #1;
    start = 0;
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("busy_high", {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 100) begin
      if (n == inj) begin start = 1; funct3 = 3'b100; a = ~x; b = 32'h3; end
      else start = 0;
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    chk($sformatf("latency f=%0d", f), n, lat);
    chk($sformatf("result f=%0d a=%h b=%h", f, x, y), result, exp);
    last = exp;
  endtask
  initial begin
    int n, seen;
    logic [31:0] x, y;
    rst = 0; start = 0; flush = 0; funct3 = 0; a = 0; b = 0; last = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1;
    @(posedge clk); #1;
    start = 1; flush = 1;
    @(posedge clk); #1;
    start = 0; flush = 0;
    chk("flush_over_start", {31'b0, busy}, 32'd0);
    run(3'd0, 32'd7, 32'hFFFF_FFFA, -1);
    run(3'd1, 32'd7, 32'hFFFF_FFFA, -1);
    run(3'd3, 32'd7, 32'hFFFF_FFFA, -1);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
    run(3'd5, 32'd100, 32'd7, -1);
    run(3'd7, 32'd100, 32'd7, -1);
    for (int f = 4; f < 8; f++) run(f[2:0], 32'h1234_5678, 32'd0, -1);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run(3'd0, 32'd3, 32'd5, 5);
    for (int i = 0; i < 48; i++) begin
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1000) : $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? $urandom_range(1, 50) : $urandom;
      if ($urandom_range(0, 1) == 1) begin @(negedge clk); end
      run(3'($urandom_range(0, 7)), x, y, -1);
    end
    @(negedge clk);
    start = 1; funct3 = 3'b101; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 0; n = 0;
    while (n < 9) begin @(posedge clk); #1; n++; end
    chk("busy_before_flush", {31'b0, busy}, 32'd1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_result", result, last);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    chk("flush_no_done", seen, 0);
    start = 1; funct3 = 3'b000; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 0; n = 0;
    while (n < 14) begin @(posedge clk); #1; n++; end
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    chk("midrst_no_done", seen, 0);
    run(3'd0, 32'd3, 32'd5, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
